sram_mem_ctrl: RTL and testbench

//  Memory access sequencer between the LC-3 control FSM and the off-chip 16-bit SRAM.
//  - Turns the FSM's level-style active-low Mem_CE/Mem_OE/Mem_WE requests into timed SRAM strobe sequences.
//  - Sequences use programmable wait states.
//  - Returns read data with a one-cycle Rdy pulse.
//  - Memory-maps I/O at 16'hFFFF: reads return Switches; writes load the hex-display register.

---
 rtl/sram_mem_ctrl.sv | 161 ++++++++++++++++
 tb/tb_sram_mem_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_mem_ctrl.sv
// ============================================================================
// Module      : sram_mem_ctrl
// Description : LC-3 memory access sequencer for a 16-bit asynchronous SRAM,
//               with a memory-mapped switch/hex-display port at IO_ADDR.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_mem_ctrl #(
    parameter int          READ_WAIT  = 2,
    parameter int          WRITE_WAIT = 2,
    parameter logic [15:0] IO_ADDR    = 16'hFFFF
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Mem_CE,
    input  logic        Mem_OE,
    input  logic        Mem_WE,
    input  logic [15:0] MAR,
    input  logic [15:0] MDR,
    input  logic [15:0] SRAM_DQ_in,
    input  logic [15:0] Switches,
    output logic [19:0] SRAM_ADDR,
    output logic [15:0] SRAM_DQ_out,
    output logic        SRAM_DQ_oe,
    output logic        SRAM_CE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_WE_N,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N,
    output logic [15:0] Data_to_CPU,
    output logic        Rdy,
    output logic        Busy,
    output logic [15:0] HEX_Data
);

    localparam int c_MAX_WAIT = (READ_WAIT > WRITE_WAIT) ? READ_WAIT : WRITE_WAIT;
    localparam int c_CNT_W    = (c_MAX_WAIT > 1) ? $clog2(c_MAX_WAIT) : 1;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RD_WAIT  = 3'd1,
        S_WR_SETUP = 3'd2,
        S_WR_PULSE = 3'd3,
        S_WR_HOLD  = 3'd4,
        S_IO       = 3'd5,
        S_DONE     = 3'd6
    } state_t;

    state_t               r_state;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [15:0]          r_mdr;
    logic                 r_io_wr;

    logic w_wr_req;
    logic w_rd_req;
    logic w_is_io;

    assign w_wr_req = ~Mem_CE & ~Mem_WE;
    assign w_rd_req = ~Mem_CE & ~Mem_OE & Mem_WE;
    assign w_is_io  = (MAR == IO_ADDR);

    // Byte lanes follow chip enable: only whole-word accesses exist.
    assign SRAM_UB_N = SRAM_CE_N;
    assign SRAM_LB_N = SRAM_CE_N;
    assign Busy      = (r_state != S_IDLE);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_mdr       <= '0;
            r_io_wr     <= 1'b0;
            SRAM_ADDR   <= '0;
            SRAM_DQ_out <= '0;
            SRAM_DQ_oe  <= 1'b0;
            SRAM_CE_N   <= 1'b1;
            SRAM_OE_N   <= 1'b1;
            SRAM_WE_N   <= 1'b1;
            Data_to_CPU <= '0;
            HEX_Data    <= '0;
            Rdy         <= 1'b0;
        end else begin
            Rdy <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_wr_req || w_rd_req) begin
                        SRAM_ADDR <= {4'h0, MAR};
                        r_mdr     <= MDR;
                        r_io_wr   <= w_wr_req;
                        if (w_is_io) begin
                            r_state <= S_IO;
                        end else if (w_wr_req) begin
                            r_state     <= S_WR_SETUP;
                            SRAM_CE_N   <= 1'b0;
                            SRAM_DQ_oe  <= 1'b1;
                            SRAM_DQ_out <= MDR;
                        end else begin
                            r_state   <= S_RD_WAIT;
                            SRAM_CE_N <= 1'b0;
                            SRAM_OE_N <= 1'b0;
                            r_cnt     <= c_CNT_W'(READ_WAIT - 1);
                        end
                    end
                end
                S_RD_WAIT: begin
                    if (r_cnt == '0) begin
                        Data_to_CPU <= SRAM_DQ_in;
                        SRAM_CE_N   <= 1'b1;
                        SRAM_OE_N   <= 1'b1;
                        Rdy         <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_WR_SETUP: begin
                    SRAM_WE_N <= 1'b0;
                    r_cnt     <= c_CNT_W'(WRITE_WAIT - 1);
                    r_state   <= S_WR_PULSE;
                end
                S_WR_PULSE: begin
                    if (r_cnt == '0) begin
                        SRAM_WE_N <= 1'b1;
                        r_state   <= S_WR_HOLD;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_WR_HOLD: begin
                    // Data stays driven through the WE_N rising edge, released here.
                    SRAM_CE_N  <= 1'b1;
                    SRAM_DQ_oe <= 1'b0;
                    Rdy        <= 1'b1;
                    r_state    <= S_DONE;
                end
                S_IO: begin
                    if (r_io_wr) begin
                        HEX_Data <= r_mdr;
                    end else begin
                        Data_to_CPU <= Switches;
                    end
                    Rdy     <= 1'b1;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    // The control FSM holds its request for several cycles; wait it out.
                    if (Mem_OE && Mem_WE) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sram_mem_ctrl.sv
// ============================================================================
// Module      : tb_sram_mem_ctrl
// Description : Self-checking bench for sram_mem_ctrl: vector table, hand
//               sequences and randomized accesses against a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sram_mem_ctrl;

    localparam int          c_RW = 2;
    localparam int          c_WW = 2;
    localparam logic [15:0] c_IO = 16'hFFFF;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Mem_CE = 1'b1;
    logic        Mem_OE = 1'b1;
    logic        Mem_WE = 1'b1;
    logic [15:0] MAR = '0;
    logic [15:0] MDR = '0;
    logic [15:0] Switches = '0;
    logic [15:0] SRAM_DQ_in;
    logic [19:0] SRAM_ADDR;
    logic [15:0] SRAM_DQ_out;
    logic        SRAM_DQ_oe;
    logic        SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N;
    logic [15:0] Data_to_CPU;
    logic        Rdy;
    logic        Busy;
    logic [15:0] HEX_Data;

    sram_mem_ctrl #(.READ_WAIT(c_RW), .WRITE_WAIT(c_WW), .IO_ADDR(c_IO)) u_dut (
        .Clk(Clk), .Reset(Reset), .Mem_CE(Mem_CE), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE),
        .MAR(MAR), .MDR(MDR), .SRAM_DQ_in(SRAM_DQ_in), .Switches(Switches),
        .SRAM_ADDR(SRAM_ADDR), .SRAM_DQ_out(SRAM_DQ_out), .SRAM_DQ_oe(SRAM_DQ_oe),
        .SRAM_CE_N(SRAM_CE_N), .SRAM_OE_N(SRAM_OE_N), .SRAM_WE_N(SRAM_WE_N),
        .SRAM_UB_N(SRAM_UB_N), .SRAM_LB_N(SRAM_LB_N), .Data_to_CPU(Data_to_CPU),
        .Rdy(Rdy), .Busy(Busy), .HEX_Data(HEX_Data)
    );

    always #5 Clk = ~Clk;

    // Asynchronous SRAM device model (256 words is enough for the tests).
    logic [15:0] sram [0:255];
    logic        pl_en = 1'b0;
    logic [7:0]  pl_a = '0;
    logic [15:0] pl_d = '0;
    assign SRAM_DQ_in = (!SRAM_CE_N && !SRAM_OE_N) ? sram[SRAM_ADDR[7:0]] : 16'hDEAD;
    always @(posedge Clk) begin
        if (pl_en) sram[pl_a] <= pl_d;
        else if (!SRAM_CE_N && !SRAM_WE_N && SRAM_DQ_oe) sram[SRAM_ADDR[7:0]] <= SRAM_DQ_out;
    end

    // Bus monitor: cumulative strobe counts and protocol violations.
    int          m_oe = 0, m_we = 0, m_dq = 0, m_rdy = 0, m_ce = 0, m_bad = 0;
    logic [19:0] exp_addr = '0;
    always @(posedge Clk) begin
        if (!Reset) begin
            if (!SRAM_OE_N) m_oe++;
            if (!SRAM_WE_N) m_we++;
            if (SRAM_DQ_oe) m_dq++;
            if (Rdy)        m_rdy++;
            if (!SRAM_CE_N) m_ce++;
            if (SRAM_DQ_oe && !SRAM_OE_N) m_bad++;
            if (!SRAM_WE_N && !SRAM_DQ_oe) m_bad++;
            if (SRAM_UB_N != SRAM_CE_N || SRAM_LB_N != SRAM_CE_N) m_bad++;
            if (!SRAM_CE_N && SRAM_ADDR != exp_addr) m_bad++;
        end
    end

    int checks = 0, failures = 0;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model state
    logic [15:0] ref_mem [0:255];
    logic [15:0] ref_dout = '0;
    logic [15:0] ref_hex = '0;
    int s_oe, s_we, s_dq, s_rdy, s_ce, s_bad;

    function automatic logic [15:0] pattern(input int a);
        return 16'(a * 16'h0101) ^ 16'h5A5A;
    endfunction

    task automatic preload(input logic [7:0] a, input logic [15:0] d);
        @(posedge Clk); #1;
        pl_a = a; pl_d = d; pl_en = 1'b1;
        @(posedge Clk); #1;
        pl_en = 1'b0;
        ref_mem[a] = d;
    endtask

    // Latency = edges after the accept edge up to the edge that samples Rdy high.
    task automatic run_access(input bit wr, input bit both, input logic [15:0] addr,
                              input logic [15:0] data, input logic [15:0] sw, input int hold,
                              output int lat, output bit busy_ok, output bit idle_ok);
        @(posedge Clk); #1;
        s_oe = m_oe; s_we = m_we; s_dq = m_dq; s_rdy = m_rdy; s_ce = m_ce; s_bad = m_bad;
        exp_addr = {4'h0, addr};
        MAR = addr; MDR = data; Switches = sw;
        Mem_CE = 1'b0; Mem_WE = wr ? 1'b0 : 1'b1; Mem_OE = (wr && !both) ? 1'b1 : 1'b0;
        lat = -1; busy_ok = 1'b1; idle_ok = 1'b0;
        @(posedge Clk);
        for (int n = 1; n <= 60; n++) begin
            @(posedge Clk);
            if (Rdy && lat < 0) lat = n;
            if (n <= hold && !Busy) busy_ok = 1'b0;
            if (n > hold && lat > 0 && !Busy) begin
                idle_ok = 1'b1;
                break;
            end
            #1;
            if (n == 1) begin MAR = 16'($urandom); MDR = 16'($urandom); end
            if (n == hold) begin Mem_CE = 1'b1; Mem_OE = 1'b1; Mem_WE = 1'b1; end
        end
        #1;
    endtask

    // Applies one access, updates the reference model and compares everything.
    task automatic do_checked(input string tag, input bit wr, input bit both,
                              input logic [15:0] addr, input logic [15:0] data,
                              input logic [15:0] sw, input int hold,
                              input bit has_exp, input int exp_lat_t, input logic [15:0] exp_val);
        int lat; bit busy_ok, idle_ok;
        bit io;
        int e_lat, e_oe, e_we, e_dq, e_ce;
        logic [15:0] got;
        io = (addr == c_IO);
        e_lat = io ? 2 : (wr ? c_WW + 3 : c_RW + 1);
        e_oe  = (!io && !wr) ? c_RW : 0;
        e_we  = (!io && wr) ? c_WW : 0;
        e_dq  = (!io && wr) ? c_WW + 2 : 0;
        e_ce  = io ? 0 : (wr ? c_WW + 2 : c_RW);
        if (io && wr)       ref_hex = data;
        else if (io)        ref_dout = sw;
        else if (wr)        ref_mem[addr[7:0]] = data;
        else                ref_dout = ref_mem[addr[7:0]];
        run_access(wr, both, addr, data, sw, hold, lat, busy_ok, idle_ok);
        got = (io && wr) ? HEX_Data : (wr ? sram[addr[7:0]] : Data_to_CPU);
        if (has_exp) begin
            check({tag, " latency(table)"}, lat, exp_lat_t);
            check({tag, " value(table)"}, got, exp_val);
        end
        check({tag, " latency"}, lat, e_lat);
        check({tag, " Data_to_CPU"}, Data_to_CPU, ref_dout);
        check({tag, " HEX_Data"}, HEX_Data, ref_hex);
        if (!io && wr) check({tag, " sram word"}, sram[addr[7:0]], data);
        check({tag, " OE_N low cycles"}, m_oe - s_oe, e_oe);
        check({tag, " WE_N low cycles"}, m_we - s_we, e_we);
        check({tag, " DQ_oe cycles"}, m_dq - s_dq, e_dq);
        check({tag, " CE_N low cycles"}, m_ce - s_ce, e_ce);
        check({tag, " Rdy pulses"}, m_rdy - s_rdy, 1);
        check({tag, " bus violations"}, m_bad - s_bad, 0);
        check({tag, " Busy while held"}, busy_ok, 1);
        check({tag, " returns to idle"}, idle_ok, 1);
    endtask

    typedef struct {
        string       name;
        bit          wr;
        bit          both;
        logic [15:0] addr;
        logic [15:0] data;
        logic [15:0] sw;
        int          hold;
        int          exp_lat;
        logic [15:0] exp_val;
    } vec_t;
    vec_t vecs [6];

    initial begin
        vecs[0] = '{"rd_0010",   1'b0, 1'b0, 16'h0010, 16'h0000, 16'h0000, 4,  3, 16'h1234};
        vecs[1] = '{"wr_0020",   1'b1, 1'b0, 16'h0020, 16'hBEEF, 16'h0000, 4,  5, 16'hBEEF};
        vecs[2] = '{"io_wr",     1'b1, 1'b0, 16'hFFFF, 16'h00A5, 16'h0000, 3,  2, 16'h00A5};
        vecs[3] = '{"io_rd",     1'b0, 1'b0, 16'hFFFF, 16'h0000, 16'h0F0F, 3,  2, 16'h0F0F};
        vecs[4] = '{"both_low",  1'b1, 1'b1, 16'h0030, 16'h7777, 16'h0000, 4,  5, 16'h7777};
        vecs[5] = '{"held_rd",   1'b0, 1'b0, 16'h0020, 16'h0000, 16'h0000, 10, 3, 16'hBEEF};

        repeat (3) @(posedge Clk);
        #1;
        check("reset SRAM_CE_N", SRAM_CE_N, 1);
        check("reset SRAM_OE_N", SRAM_OE_N, 1);
        check("reset SRAM_WE_N", SRAM_WE_N, 1);
        check("reset UB/LB", {SRAM_UB_N, SRAM_LB_N}, 2'b11);
        check("reset DQ_oe", SRAM_DQ_oe, 0);
        check("reset ADDR/DQ_out", {SRAM_ADDR, SRAM_DQ_out}, 36'h0);
        check("reset Data/HEX", {Data_to_CPU, HEX_Data}, 32'h0);
        check("reset Rdy/Busy", {Rdy, Busy}, 2'b00);

        for (int i = 0; i < 256; i++) begin
            sram[i] = pattern(i);
            ref_mem[i] = pattern(i);
        end
        Reset = 1'b0;
        preload(8'h10, 16'h1234);

        for (int i = 0; i < 6; i++)
            do_checked(vecs[i].name, vecs[i].wr, vecs[i].both, vecs[i].addr, vecs[i].data,
                       vecs[i].sw, vecs[i].hold, 1'b1, vecs[i].exp_lat, vecs[i].exp_val);

        for (int i = 0; i < 40; i++) begin
            bit wr;
            logic [15:0] a;
            wr = 1'($urandom);
            a = ($urandom_range(0, 4) == 0) ? c_IO : 16'($urandom_range(0, 255));
            do_checked($sformatf("rand%0d", i), wr, wr & 1'($urandom), a, 16'($urandom),
                       16'($urandom), int'($urandom_range(1, 8)), 1'b0, 0, 16'h0);
        end

        // Reset in the middle of the write strobe must abort cleanly.
        begin
            bit seen_we;
            seen_we = 1'b0;
            @(posedge Clk); #1;
            s_rdy = m_rdy;
            exp_addr = 20'h00040;
            MAR = 16'h0040; MDR = 16'h1111; Mem_CE = 1'b0; Mem_WE = 1'b0; Mem_OE = 1'b1;
            for (int n = 0; n < 20; n++) begin
                @(posedge Clk); #1;
                if (!SRAM_WE_N) begin
                    seen_we = 1'b1;
                    break;
                end
            end
            check("mid-write WE_N reached", seen_we, 1);
            Reset = 1'b1; Mem_CE = 1'b1; Mem_WE = 1'b1;
            @(posedge Clk); #1;
            check("abort WE_N", SRAM_WE_N, 1);
            check("abort CE_N/OE_N", {SRAM_CE_N, SRAM_OE_N}, 2'b11);
            check("abort DQ_oe", SRAM_DQ_oe, 0);
            check("abort Busy", Busy, 0);
            check("abort Rdy", Rdy, 0);
            check("abort ADDR/Data/HEX", {SRAM_ADDR, Data_to_CPU, HEX_Data}, 52'h0);
            Reset = 1'b0;
            repeat (8) @(posedge Clk);
            #1;
            check("abort no Rdy pulse", m_rdy - s_rdy, 0);
            check("abort stays idle", Busy, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
